// File: rtl/counter_updown_mod_param.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_mod_param
// Purpose  : Up/down modulo counter with load, clear, wrap/saturate mode,
//            a terminal-count flag and a one-cycle wrap pulse.
// Revision : 1.0 - initial release
// ============================================================================
module counter_updown_mod_param #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             terminal,
  output logic             wrap
);

  // Bounds are held one bit wider than the count so MODULUS = 2^WIDTH is representable.
  localparam logic [64:0]    c_span = 65'd1 << WIDTH;
  localparam logic [WIDTH:0] c_mod  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] c_max  = (WIDTH+1)'(MODULUS - 64'd1);
  localparam bit             c_sat  = (SATURATE != 0);

  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("counter_updown_mod_param: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || 65'(MODULUS) > c_span) begin : g_bad_modulus
      $error("counter_updown_mod_param: MODULUS must be in 2..2**WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] r_out;
  logic             r_wrap;

  logic [WIDTH:0]   w_out_ext;
  logic [WIDTH:0]   w_load_ext;
  logic             w_at_max;
  logic             w_at_min;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next_out;
  logic             w_next_wrap;

  assign w_out_ext      = {1'b0, r_out};
  assign w_load_ext     = {1'b0, load_value};
  assign w_at_max       = (w_out_ext == c_max);
  assign w_at_min       = (r_out == '0);
  assign w_inc          = r_out + 1'b1;
  assign w_dec          = r_out - 1'b1;
  assign w_load_clamped = (w_load_ext >= c_mod) ? c_max[WIDTH-1:0] : load_value;

  // Priority: clear, load, count, hold. Wrap is only raised by a bound crossing.
  always_comb begin
    w_next_out  = r_out;
    w_next_wrap = 1'b0;
    if (clear) begin
      w_next_out = '0;
    end else if (load) begin
      w_next_out = w_load_clamped;
    end else if (enable) begin
      if (up_down) begin
        if (!w_at_max) begin
          w_next_out = w_inc;
        end else if (!c_sat) begin
          w_next_out  = '0;
          w_next_wrap = 1'b1;
        end
      end else begin
        if (!w_at_min) begin
          w_next_out = w_dec;
        end else if (!c_sat) begin
          w_next_out  = c_max[WIDTH-1:0];
          w_next_wrap = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_out  <= w_next_out;
      r_wrap <= w_next_wrap;
    end
  end

  assign out      = r_out;
  assign wrap     = r_wrap;
  assign terminal = up_down ? w_at_max : w_at_min;

endmodule
`default_nettype wire

// File: tb/tb_counter_updown_mod_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_updown_mod_param
// Purpose  : Self-checking bench; four counter configurations share one set
//            of controls and are compared against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_updown_mod_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic       clear;
  logic [3:0] load_value;

  wire  [3:0] out0, out1, out2;
  wire        out3;
  wire  [3:0] d_term;
  wire  [3:0] d_wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // Configurations: (W4,M10,wrap) (W4,M10,sat) (W4,M16,wrap) (W1,M2,wrap)
  int c_mod [4] = '{10, 10, 16, 2};
  int c_sat [4] = '{0, 1, 0, 0};
  int c_wid [4] = '{4, 4, 4, 1};
  int m_out [4];
  bit m_wrap[4];

  always #5 clock = ~clock;

  counter_updown_mod_param #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_d0 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear(clear), .out(out0), .terminal(d_term[0]), .wrap(d_wrap[0]));
  counter_updown_mod_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_d1 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear(clear), .out(out1), .terminal(d_term[1]), .wrap(d_wrap[1]));
  counter_updown_mod_param #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_d2 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value), .clear(clear), .out(out2), .terminal(d_term[2]), .wrap(d_wrap[2]));
  counter_updown_mod_param #(.WIDTH(1), .MODULUS(2), .SATURATE(0)) u_d3 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .load(load),
    .load_value(load_value[0:0]), .clear(clear), .out(out3), .terminal(d_term[3]), .wrap(d_wrap[3]));

  function automatic logic [3:0] dut_out(int k);
    case (k)
      0:       return out0;
      1:       return out1;
      2:       return out2;
      default: return {3'b000, out3};
    endcase
  endfunction

  function automatic bit m_term(int k);
    return up_down ? (m_out[k] == c_mod[k] - 1) : (m_out[k] == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_out[k]  = 0;
      m_wrap[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int lv;
      lv        = int'(load_value) % (1 << c_wid[k]);
      m_wrap[k] = 1'b0;
      if (clear) begin
        m_out[k] = 0;
      end else if (load) begin
        m_out[k] = (lv >= c_mod[k]) ? c_mod[k] - 1 : lv;
      end else if (enable) begin
        if (up_down) begin
          if (m_out[k] < c_mod[k] - 1) m_out[k] = m_out[k] + 1;
          else if (c_sat[k] == 0) begin m_out[k] = 0; m_wrap[k] = 1'b1; end
        end else begin
          if (m_out[k] > 0) m_out[k] = m_out[k] - 1;
          else if (c_sat[k] == 0) begin m_out[k] = c_mod[k] - 1; m_wrap[k] = 1'b1; end
        end
      end
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [3:0] lv, input logic e, input logic ud);
    @(negedge clock);
    clear = c; load = l; load_value = lv; enable = e; up_down = ud;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; up_down = 1'b1; load = 1'b0; clear = 1'b0; load_value = 4'd0;
    model_reset();
    for (int t = 0; t < 3; t++) begin
      #3;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'd0 || d_wrap[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_hold dut%0d t=%0t: out=%0d wrap=%b, expected out=0 wrap=0", k, $time, dut_out(k), d_wrap[k]);
        end
      end
      #2;
    end
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, (i == 3));
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'(m_out[k]) || d_wrap[k] !== m_wrap[k] || d_term[k] !== m_term(k)) begin
          n_fail++;
          $display("FAIL reset_release dut%0d t=%0t: out=%0d wrap=%b term=%b, expected out=%0d wrap=%b term=%b",
                   k, $time, dut_out(k), d_wrap[k], d_term[k], m_out[k], m_wrap[k], m_term(k));
        end
      end
    end
  endtask

  task automatic test_up_wrap();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      n_checks++;
      if (out0 !== 4'((i + 1) % 10) || d_wrap[0] !== (i == 9)) begin
        n_fail++;
        $display("FAIL up_wrap_seq step%0d: out=%0d wrap=%b, expected out=%0d wrap=%b", i, out0, d_wrap[0], (i + 1) % 10, (i == 9));
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'(m_out[k]) || d_wrap[k] !== m_wrap[k] || d_term[k] !== m_term(k)) begin
          n_fail++;
          $display("FAIL up_wrap dut%0d t=%0t: out=%0d wrap=%b term=%b, expected out=%0d wrap=%b term=%b",
                   k, $time, dut_out(k), d_wrap[k], d_term[k], m_out[k], m_wrap[k], m_term(k));
        end
      end
    end
  endtask

  task automatic test_down_dir();
    logic [3:0] exp_seq [6];
    exp_seq = '{4'd1, 4'd0, 4'd9, 4'd8, 4'd9, 4'd0};
    step(1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, (i >= 4));
      n_checks++;
      if (out0 !== exp_seq[i] || d_wrap[0] !== (i == 2 || i == 5)) begin
        n_fail++;
        $display("FAIL down_dir_seq step%0d: out=%0d wrap=%b, expected out=%0d wrap=%b", i, out0, d_wrap[0], exp_seq[i], (i == 2 || i == 5));
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'(m_out[k]) || d_wrap[k] !== m_wrap[k] || d_term[k] !== m_term(k)) begin
          n_fail++;
          $display("FAIL down_dir dut%0d t=%0t: out=%0d wrap=%b term=%b, expected out=%0d wrap=%b term=%b",
                   k, $time, dut_out(k), d_wrap[k], d_term[k], m_out[k], m_wrap[k], m_term(k));
        end
      end
    end
  endtask

  task automatic test_saturate();
    logic [3:0] exp_up [5];
    exp_up = '{4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      else if (i == 5) begin
        step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      end else step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      n_checks++;
      if (out1 !== ((i < 5) ? exp_up[i] : 4'd0) || d_wrap[1] !== 1'b0 || (i >= 5 && d_term[1] !== 1'b1)) begin
        n_fail++;
        $display("FAIL saturate_seq step%0d: out=%0d wrap=%b term=%b, expected out=%0d wrap=0",
                 i, out1, d_wrap[1], d_term[1], (i < 5) ? exp_up[i] : 4'd0);
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'(m_out[k]) || d_wrap[k] !== m_wrap[k] || d_term[k] !== m_term(k)) begin
          n_fail++;
          $display("FAIL saturate dut%0d t=%0t: out=%0d wrap=%b term=%b, expected out=%0d wrap=%b term=%b",
                   k, $time, dut_out(k), d_wrap[k], d_term[k], m_out[k], m_wrap[k], m_term(k));
        end
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] exp_p [3];
    exp_p = '{4'd0, 4'd9, 4'd5};
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       step(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
        1:       step(1'b0, 1'b1, 4'd13, 1'b0, 1'b1);
        default: step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
      endcase
      n_checks++;
      if (out0 !== exp_p[i]) begin
        n_fail++;
        $display("FAIL priority_case%0d: out=%0d, expected %0d", i, out0, exp_p[i]);
      end
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'(m_out[k]) || d_wrap[k] !== m_wrap[k] || d_term[k] !== m_term(k)) begin
          n_fail++;
          $display("FAIL priority dut%0d t=%0t: out=%0d wrap=%b term=%b, expected out=%0d wrap=%b term=%b",
                   k, $time, dut_out(k), d_wrap[k], d_term[k], m_out[k], m_wrap[k], m_term(k));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 4'd6, 1'b0, 1'b1);
    @(negedge clock);
    load = 1'b1; load_value = 4'd3; enable = 1'b1; clear = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    for (int t = 0; t < 2; t++) begin
      #1;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'd0 || d_wrap[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL async_reset dut%0d t=%0t: out=%0d wrap=%b, expected out=0 wrap=0", k, $time, dut_out(k), d_wrap[k]);
        end
      end
      @(posedge clock);
    end
    @(negedge clock);
    load = 1'b0; enable = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_full_range();
    int pulses = 0;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      if (d_wrap[2] === 1'b1) pulses++;
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'(m_out[k]) || d_wrap[k] !== m_wrap[k] || d_term[k] !== m_term(k)) begin
          n_fail++;
          $display("FAIL full_range dut%0d t=%0t: out=%0d wrap=%b term=%b, expected out=%0d wrap=%b term=%b",
                   k, $time, dut_out(k), d_wrap[k], d_term[k], m_out[k], m_wrap[k], m_term(k));
        end
      end
    end
    n_checks++;
    if (out2 !== 4'd1 || pulses != 1) begin
      n_fail++;
      $display("FAIL full_range_end: out=%0d pulses=%0d, expected out=1 pulses=1", out2, pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0), 1'($urandom));
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (dut_out(k) !== 4'(m_out[k]) || d_wrap[k] !== m_wrap[k] || d_term[k] !== m_term(k)) begin
          n_fail++;
          $display("FAIL random dut%0d t=%0t: out=%0d wrap=%b term=%b, expected out=%0d wrap=%b term=%b",
                   k, $time, dut_out(k), d_wrap[k], d_term[k], m_out[k], m_wrap[k], m_term(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_dir();
    test_saturate();
    test_priority();
    test_async_reset();
    test_full_range();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/counter_updown_mod_param.md
Name: counter_updown_mod_param

Overview:
Parametrised synchronous up/down counter with a configurable modulus, the next generation of the fixed 4-bit up counter with enable. It adds width and modulus parameters, count direction, synchronous load and clear, a wrap or saturate mode, and terminal-count and wrap-pulse outputs. It is a reusable timebase and event-counting block for the module library. One clock domain.

Parameters:
WIDTH, 4, counter width in bits (1..32).
MODULUS, 16, count range 0..MODULUS-1; legal range 2..2^WIDTH; elaboration error outside this range.
SATURATE, 0, 0 = wrap at the bounds; 1 = hold at the bounds.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously (external synchroniser).
enable  input  1  count enable, active-high.
up_down  input  1  1 = count up, 0 = count down; sampled only when counting.
load  input  1  synchronous load strobe, active-high.
load_value  input  WIDTH  value written on load.
clear  input  1  synchronous clear to 0, active-high.
out  output  WIDTH  registered count value.
terminal  output  1  combinational; 1 when out is at the bound for the current direction (MODULUS-1 if up_down=1, 0 if up_down=0).
wrap  output  1  registered one-cycle pulse, asserted the cycle after out wraps.

Behaviour:
- reset low: out=0 and wrap=0 immediately, independent of clock; both hold while reset is low.
- First rising edge after reset goes high acts normally.
- Per-edge priority, highest first: clear, load, enable count, hold.
- clear=1: out<=0, wrap<=0; load and enable are ignored.
- load=1 (clear=0): out<=load_value.
  - If load_value >= MODULUS, out<=MODULUS-1 (clamp).
  - wrap<=0; enable is ignored that cycle.
- enable=1, up_down=1: out<=out+1.
  - At out=MODULUS-1 with SATURATE=0: out<=0 and wrap<=1.
  - At out=MODULUS-1 with SATURATE=1: out holds and wrap<=0.
- enable=1, up_down=0: out<=out-1.
  - At out=0 with SATURATE=0: out<=MODULUS-1 and wrap<=1.
  - At out=0 with SATURATE=1: out holds and wrap<=0.
- enable=0 with no clear or load: out holds, wrap<=0.
- wrap is high for exactly one cycle per wrap event. Consecutive wraps (e.g. MODULUS=2 counting continuously) give consecutive high cycles.
- Latency: one clock from input to out change. terminal follows out and up_down combinationally with no extra latency.
- Arithmetic: internal compares are WIDTH+1 bits wide, so MODULUS=2^WIDTH wraps naturally with no overflow artefact. out never leaves 0..MODULUS-1 under any input sequence.
- Direction change mid-count takes effect on the next enabled edge; no state beyond out and wrap.
- reset asserted mid-count: out and wrap go to 0 asynchronously and pending load, clear and enable are discarded.
- X or Z on control inputs is not a supported input condition. The bench keeps all controls driven.

Test Plan:
1. Reset and hold: reset low for 15 ns with enable=1 -> out=0 and wrap=0 throughout. After release with enable=0 for 3 cycles -> out stays 0. terminal=1 while up_down=0, terminal=0 while up_down=1.
2. Up wrap (WIDTH=4, MODULUS=10, SATURATE=0): enable=1, up_down=1 for 12 cycles -> out sequence 1..9,0,1,2. terminal=1 only while out=9. wrap=1 for exactly the one cycle after out becomes 0.
3. Down wrap and direction change: load 2, then up_down=0 with enable=1 for 4 cycles -> out 1,0,9,8, with the wrap pulse after the 0->9 transition. Then set up_down=1 for 2 cycles -> out 9,0, with a wrap pulse.
4. Saturate (MODULUS=10, SATURATE=1): count up from 7 for 5 cycles -> out 8,9,9,9,9 and wrap never asserts. Count down from 1 -> out 0,0, and terminal stays 1 once out=0.
5. Priority and clamp:
   - clear=1, load=1, enable=1 together -> out=0.
   - load=1 with load_value=13 and MODULUS=10 -> out=9.
   - load=1 with load_value=5 and enable=1 -> out=5, not 6.
6. Async reset mid-count and full-range parameters:
   - Drive reset low between edges while out=6 -> out=0 before the next edge.
   - WIDTH=4, MODULUS=16 counting up 17 cycles -> out wraps 15->0 with one wrap pulse and ends at out=1.
